// File: rtl/ulam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ulam_pkg
// Description : Shared state encoding and helpers for the Ulam run controller
// Revision    : 1.0
// ============================================================================
package ulam_pkg;

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_CLEAR  = 3'd1;
    localparam logic [2:0] C_ST_LOAD   = 3'd2;
    localparam logic [2:0] C_ST_RUN    = 3'd3;
    localparam logic [2:0] C_ST_FINISH = 3'd4;
    localparam logic [2:0] C_ST_ABORT  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_CLEAR  = C_ST_CLEAR,
        ST_LOAD   = C_ST_LOAD,
        ST_RUN    = C_ST_RUN,
        ST_FINISH = C_ST_FINISH,
        ST_ABORT  = C_ST_ABORT
    } state_t;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : ulam_pkg
`default_nettype wire

// File: rtl/ulam_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : ulam_step_timer
// Description : Step prescaler, step counter and watchdog compare
// Revision    : 1.0
// ============================================================================
module ulam_step_timer
    import ulam_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 1000,
    parameter int STEP_DIV   = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             active,
    output logic             go,
    output logic [CNT_W-1:0] step_count,
    output logic             wdog_hit
);

    localparam int                 c_pre_w    = clog2(STEP_DIV);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0]   c_limit    = CNT_W'(WDOG_LIMIT);

    logic [c_pre_w-1:0] r_pre;
    logic               r_go;
    logic [CNT_W-1:0]   r_cnt;

    // active means the controller will be in RUN next cycle, so go and the
    // count become visible in the same cycle they are issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_go  <= 1'b0;
            r_cnt <= '0;
        end else if (restart) begin
            r_pre <= '0;
            r_go  <= 1'b0;
            r_cnt <= '0;
        end else if (active) begin
            if (r_pre == c_pre_last) begin
                r_pre <= '0;
                if (r_cnt != c_limit) begin
                    r_go  <= 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_go  <= 1'b0;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
                r_go  <= 1'b0;
            end
        end else begin
            r_pre <= '0;
            r_go  <= 1'b0;
        end
    end

    assign go         = r_go;
    assign step_count = r_cnt;
    assign wdog_hit   = (r_cnt == c_limit);

endmodule : ulam_step_timer
`default_nettype wire

// File: rtl/ulam_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ulam_run_ctrl
// Description : Multi-channel Ulam iteration run controller (Moore outputs)
// Revision    : 1.0
// ============================================================================
module ulam_run_ctrl
    import ulam_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int CNT_W        = 16,
    parameter int WDOG_LIMIT   = 1000,
    parameter int STEP_DIV     = 1,
    parameter int AUTO_RESTART = 0,
    parameter int IDX_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             alert,
    input  logic [NCH-1:0]   done,
    output logic             clear,
    output logic             enable,
    output logic             run,
    output logic             go,
    output logic             busy,
    output logic             finished,
    output logic             timed_out,
    output logic             aborted,
    output logic [NCH-1:0]   done_mask,
    output logic [CNT_W-1:0] step_count,
    output logic [IDX_W-1:0] run_index
);

    state_t           r_state;
    state_t           w_next;
    logic             w_set_aborted;
    logic             w_set_timeout;
    logic             w_wdog_hit;

    logic             r_clear;
    logic             r_enable;
    logic             r_run;
    logic             r_busy;
    logic             r_finished;
    logic             r_timed_out;
    logic             r_aborted;
    logic [NCH-1:0]   r_done_mask;
    logic [IDX_W-1:0] r_run_index;

    ulam_step_timer #(
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (WDOG_LIMIT),
        .STEP_DIV   (STEP_DIV)
    ) u_step_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .restart    (w_next == ST_CLEAR),
        .active     (w_next == ST_RUN),
        .go         (go),
        .step_count (step_count),
        .wdog_hit   (w_wdog_hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_aborted = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_next = ST_RUN;
            end
            ST_RUN: begin
                // Completion outranks the watchdog when both land together.
                if (abort || alert) begin
                    w_next        = ST_ABORT;
                    w_set_aborted = 1'b1;
                end else if (&(r_done_mask | done)) begin
                    w_next = ST_FINISH;
                end else if (w_wdog_hit) begin
                    w_next        = ST_ABORT;
                    w_set_timeout = 1'b1;
                end
            end
            ST_FINISH: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if ((AUTO_RESTART != 0) || start) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_ABORT: begin
                if (start) begin
                    w_next = ST_CLEAR;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clear    <= 1'b0;
            r_enable   <= 1'b0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_clear    <= (w_next == ST_CLEAR);
            r_enable   <= (w_next == ST_LOAD);
            r_run      <= (w_next == ST_RUN);
            r_busy     <= (w_next == ST_CLEAR) || (w_next == ST_LOAD) ||
                          (w_next == ST_RUN);
            r_finished <= (w_next == ST_FINISH);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timed_out <= 1'b0;
            r_aborted   <= 1'b0;
            r_done_mask <= '0;
        end else if (w_next == ST_CLEAR) begin
            r_timed_out <= 1'b0;
            r_aborted   <= 1'b0;
            r_done_mask <= '0;
        end else if (r_state == ST_RUN) begin
            r_done_mask <= r_done_mask | done;
            if (w_set_aborted) begin
                r_aborted <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run_index <= '0;
        end else if ((r_state != ST_FINISH) && (w_next == ST_FINISH)) begin
            r_run_index <= r_run_index + 1'b1;
        end
    end

    assign clear     = r_clear;
    assign enable    = r_enable;
    assign run       = r_run;
    assign busy      = r_busy;
    assign finished  = r_finished;
    assign timed_out = r_timed_out;
    assign aborted   = r_aborted;
    assign done_mask = r_done_mask;
    assign run_index = r_run_index;

endmodule : ulam_run_ctrl
`default_nettype wire

// File: tb/tb_ulam_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ulam_run_ctrl
// Description : Directed bench for ulam_run_ctrl with three parameter sets
// Revision    : 1.0
// ============================================================================
module tb_ulam_run_ctrl;

    logic clock;
    logic reset_n;
    int   n_assert;
    int   n_fail;
    int   gos;

    // A: NCH=2, STEP_DIV=1, WDOG_LIMIT=8
    logic a_start, a_abort, a_alert;
    logic [1:0] a_done;
    logic a_clear, a_enable, a_run, a_go, a_busy, a_finished, a_timed_out, a_aborted;
    logic [1:0] a_done_mask;
    logic [15:0] a_step_count;
    logic [7:0] a_run_index;

    // B: STEP_DIV=3, WDOG_LIMIT=20
    logic b_start, b_abort, b_alert;
    logic [1:0] b_done;
    logic b_clear, b_enable, b_run, b_go, b_busy, b_finished, b_timed_out, b_aborted;
    logic [1:0] b_done_mask;
    logic [15:0] b_step_count;
    logic [7:0] b_run_index;

    // C: AUTO_RESTART=1, IDX_W=2
    logic c_start, c_abort, c_alert;
    logic [1:0] c_done;
    logic c_clear, c_enable, c_run, c_go, c_busy, c_finished, c_timed_out, c_aborted;
    logic [1:0] c_done_mask;
    logic [15:0] c_step_count;
    logic [1:0] c_run_index;

    ulam_run_ctrl #(.NCH(2), .CNT_W(16), .WDOG_LIMIT(8), .STEP_DIV(1),
                    .AUTO_RESTART(0), .IDX_W(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(a_start), .abort(a_abort),
        .alert(a_alert), .done(a_done), .clear(a_clear), .enable(a_enable),
        .run(a_run), .go(a_go), .busy(a_busy), .finished(a_finished),
        .timed_out(a_timed_out), .aborted(a_aborted), .done_mask(a_done_mask),
        .step_count(a_step_count), .run_index(a_run_index));

    ulam_run_ctrl #(.NCH(2), .CNT_W(16), .WDOG_LIMIT(20), .STEP_DIV(3),
                    .AUTO_RESTART(0), .IDX_W(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(b_start), .abort(b_abort),
        .alert(b_alert), .done(b_done), .clear(b_clear), .enable(b_enable),
        .run(b_run), .go(b_go), .busy(b_busy), .finished(b_finished),
        .timed_out(b_timed_out), .aborted(b_aborted), .done_mask(b_done_mask),
        .step_count(b_step_count), .run_index(b_run_index));

    ulam_run_ctrl #(.NCH(2), .CNT_W(16), .WDOG_LIMIT(8), .STEP_DIV(1),
                    .AUTO_RESTART(1), .IDX_W(2)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(c_start), .abort(c_abort),
        .alert(c_alert), .done(c_done), .clear(c_clear), .enable(c_enable),
        .run(c_run), .go(c_go), .busy(c_busy), .finished(c_finished),
        .timed_out(c_timed_out), .aborted(c_aborted), .done_mask(c_done_mask),
        .step_count(c_step_count), .run_index(c_run_index));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, " clear"},      {31'd0, a_clear},     32'd0);
        check({tag, " enable"},     {31'd0, a_enable},    32'd0);
        check({tag, " run"},        {31'd0, a_run},       32'd0);
        check({tag, " go"},         {31'd0, a_go},        32'd0);
        check({tag, " busy"},       {31'd0, a_busy},      32'd0);
        check({tag, " finished"},   {31'd0, a_finished},  32'd0);
        check({tag, " timed_out"},  {31'd0, a_timed_out}, 32'd0);
        check({tag, " aborted"},    {31'd0, a_aborted},   32'd0);
        check({tag, " done_mask"},  {30'd0, a_done_mask}, 32'd0);
        check({tag, " step_count"}, {16'd0, a_step_count}, 32'd0);
        check({tag, " run_index"},  {24'd0, a_run_index}, 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        a_start = 0; a_abort = 0; a_alert = 0; a_done = 2'b00;
        b_start = 0; b_abort = 0; b_alert = 0; b_done = 2'b00;
        c_start = 0; c_abort = 0; c_alert = 0; c_done = 2'b00;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check_a_zero("reset");
        step();
        step();
        reset_n = 1'b1;

        // 1. single run
        a_start = 1;
        step();
        a_start = 0;
        check("t1 clear",  {31'd0, a_clear},  32'd1);
        check("t1 busy",   {31'd0, a_busy},   32'd1);
        check("t1 enable0", {31'd0, a_enable}, 32'd0);
        step();
        check("t1 enable", {31'd0, a_enable}, 32'd1);
        check("t1 clear0", {31'd0, a_clear},  32'd0);
        step();
        check("t1 run",    {31'd0, a_run},    32'd1);
        check("t1 go1",    {31'd0, a_go},     32'd1);
        check("t1 cnt1",   {16'd0, a_step_count}, 32'd1);
        step();
        step();
        check("t1 cnt3",   {16'd0, a_step_count}, 32'd3);
        a_done = 2'b01;
        step();
        a_done = 2'b00;
        check("t1 mask01", {30'd0, a_done_mask}, 32'd1);
        step();
        check("t1 cnt5",   {16'd0, a_step_count}, 32'd5);
        a_done = 2'b10;
        step();
        a_done = 2'b00;
        check("t1 finished", {31'd0, a_finished}, 32'd1);
        check("t1 run0",     {31'd0, a_run},      32'd0);
        check("t1 go0",      {31'd0, a_go},       32'd0);
        check("t1 cnt",      {16'd0, a_step_count}, 32'd5);
        check("t1 index",    {24'd0, a_run_index}, 32'd1);
        check("t1 timed_out", {31'd0, a_timed_out}, 32'd0);
        check("t1 mask11",   {30'd0, a_done_mask}, 32'd3);

        // 2. watchdog
        a_start = 1;
        step();
        a_start = 0;
        check("t2 cnt clr",  {16'd0, a_step_count}, 32'd0);
        check("t2 mask clr", {30'd0, a_done_mask},  32'd0);
        step();
        gos = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            gos += int'(a_go);
        end
        check("t2 go pulses", gos, 32'd8);
        check("t2 timed_out", {31'd0, a_timed_out}, 32'd1);
        check("t2 aborted",   {31'd0, a_aborted},   32'd0);
        check("t2 cnt",       {16'd0, a_step_count}, 32'd8);
        check("t2 run",       {31'd0, a_run},       32'd0);
        check("t2 busy",      {31'd0, a_busy},      32'd0);
        check("t2 index",     {24'd0, a_run_index}, 32'd1);

        // 3a. last done coincides with watchdog count
        a_start = 1;
        step();
        a_start = 0;
        check("t3a timed_out clr", {31'd0, a_timed_out}, 32'd0);
        step();
        step();
        step();
        a_done = 2'b01;
        step();
        a_done = 2'b00;
        for (int i = 0; i < 5; i++) step();
        check("t3a cnt8", {16'd0, a_step_count}, 32'd8);
        a_done = 2'b10;
        step();
        a_done = 2'b00;
        check("t3a finished",  {31'd0, a_finished},  32'd1);
        check("t3a timed_out", {31'd0, a_timed_out}, 32'd0);
        check("t3a index",     {24'd0, a_run_index}, 32'd2);
        check("t3a cnt",       {16'd0, a_step_count}, 32'd8);

        // 3b. alert together with final done
        a_start = 1;
        step();
        a_start = 0;
        step();
        step();
        a_done = 2'b01;
        step();
        a_done = 2'b10;
        a_alert = 1;
        step();
        a_done = 2'b00;
        a_alert = 0;
        check("t3b aborted",  {31'd0, a_aborted},  32'd1);
        check("t3b finished", {31'd0, a_finished}, 32'd0);
        check("t3b timed_out", {31'd0, a_timed_out}, 32'd0);
        check("t3b index",    {24'd0, a_run_index}, 32'd2);
        check("t3b cnt",      {16'd0, a_step_count}, 32'd2);
        check("t3b mask",     {30'd0, a_done_mask}, 32'd3);
        step();
        check("t3b hold",     {31'd0, a_aborted},  32'd1);

        // 4. prescaler
        b_start = 1;
        step();
        b_start = 0;
        step();
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("t4 go cyc%0d", i), {31'd0, b_go}, ((i % 3) == 0) ? 32'd1 : 32'd0);
            check($sformatf("t4 cnt cyc%0d", i), {16'd0, b_step_count}, i / 3);
        end
        b_abort = 1;
        step();
        b_abort = 0;
        check("t4 aborted", {31'd0, b_aborted}, 32'd1);
        check("t4 cnt",     {16'd0, b_step_count}, 32'd3);

        // 5. auto-restart with index wrap
        c_start = 1;
        step();
        c_start = 0;
        c_done = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            step();
            step();
            check($sformatf("t5 go r%0d", k), {31'd0, c_go}, 32'd1);
            step();
            check($sformatf("t5 fin r%0d", k), {31'd0, c_finished}, 32'd1);
            check($sformatf("t5 idx r%0d", k), {30'd0, c_run_index}, k % 4);
            step();
            check($sformatf("t5 clr r%0d", k), {31'd0, c_clear}, 32'd1);
        end
        c_done = 2'b00;

        // 6. reset mid-run
        a_start = 1;
        step();
        a_start = 0;
        step();
        for (int i = 0; i < 4; i++) step();
        check("t6 cnt4", {16'd0, a_step_count}, 32'd4);
        #2 reset_n = 1'b0;
        #1;
        check_a_zero("t6 async");
        step();
        reset_n = 1'b1;
        step();
        step();
        check("t6 idle busy",  {31'd0, a_busy},  32'd0);
        check("t6 idle clear", {31'd0, a_clear}, 32'd0);
        a_start = 1;
        step();
        a_start = 0;
        check("t6 restart clear", {31'd0, a_clear}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ulam_run_ctrl
`default_nettype wire

// File: doc/ulam_run_ctrl.md
Name: ulam_run_ctrl

Overview:
- Parametrised run controller for the Ulam (Collatz) iteration datapaths; supersedes the single-channel start/alert controller.
- Sequences clear, seed load and stepping across NCH parallel channels, with a built-in step-count watchdog, an optional step prescaler and an auto-restart sweep mode.
- Sits between the host start/abort controls and the per-channel iteration datapaths.

Parameters:
- NCH, 4, number of iteration channels driven in lockstep.
- CNT_W, 16, width of the step counter and of step_count.
- WDOG_LIMIT, 1000, step count at which a run is declared timed out; legal range 1..2^CNT_W-1.
- STEP_DIV, 1, clock cycles per step strobe (go); minimum 1.
- AUTO_RESTART, 0, 1 = return from FINISH to CLEAR automatically and increment run_index.
- IDX_W, 8, width of run_index.

Ports:
- clock  in  1  system clock, all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled request to begin a run; accepted only in IDLE, FINISH or ABORT
- abort  in  1  host abort request
- alert  in  1  external fault input (overflow from a datapath)
- done  in  NCH  per-channel "sequence reached 1" flags
- clear  out  1  one-cycle datapath clear strobe
- enable  out  1  one-cycle seed-load strobe
- run  out  1  high throughout the RUN state
- go  out  1  one-cycle step strobe
- busy  out  1  high in CLEAR, LOAD and RUN
- finished  out  1  high in FINISH
- timed_out  out  1  sticky flag: the last run ended on the watchdog
- aborted  out  1  sticky flag: the last run ended on abort or alert
- done_mask  out  NCH  sticky per-channel completion flags for the current run
- step_count  out  CNT_W  go strobes issued in the current run
- run_index  out  IDX_W  completed-run counter

Behaviour:
- Reset (asynchronous on reset_n low):
  - state = IDLE.
  - All outputs and internal counters = 0.
- States: IDLE, CLEAR, LOAD, RUN, FINISH, ABORT. One state transition per clock.
- IDLE:
  - start=1 -> CLEAR.
- CLEAR:
  - clear=1 for exactly this cycle.
  - Zeroes done_mask, step_count, timed_out, aborted and the prescaler.
  - Unconditionally -> LOAD.
- LOAD:
  - enable=1 for exactly this cycle.
  - Unconditionally -> RUN.
- RUN:
  - run=1 every cycle.
  - Prescaler counts 0..STEP_DIV-1; go=1 on cycles where prescaler==STEP_DIV-1, and step_count increments on that go.
  - STEP_DIV=1 means go on every RUN cycle. The first go falls on the STEP_DIV-th RUN cycle.
  - done_mask |= done every cycle.
  - Exits, evaluated in this priority order:
    1. abort or alert -> ABORT, aborted=1.
    2. (done_mask | done) all ones -> FINISH.
    3. step_count == WDOG_LIMIT -> ABORT, timed_out=1.
  - No go is issued on the cycle an exit is taken.
  - start is ignored in RUN.
- FINISH:
  - finished=1; run_index increments once on entry and wraps modulo 2^IDX_W.
  - AUTO_RESTART=1 -> CLEAR next cycle.
  - AUTO_RESTART=0 -> stay until start, then -> CLEAR.
  - abort in FINISH -> IDLE.
- ABORT:
  - Outputs hold timed_out/aborted, done_mask and step_count for inspection.
  - start -> CLEAR; abort=0 with start=0 holds.
  - Never auto-restarts.
- Counter rules:
  - step_count never exceeds WDOG_LIMIT.
  - The prescaler is held at 0 outside RUN.
- done bits asserted outside RUN are ignored and not latched.
- All outputs are registered (Moore); there is no combinational input-to-output path.

Decomposition:
- ulam_pkg:
  - state enum (IDLE, CLEAR, LOAD, RUN, FINISH, ABORT).
  - State encoding localparams.
  - Function clog2 for the prescaler width.
- Sub-module ulam_step_timer:
  - Contains the prescaler, step counter and watchdog compare.
  - Inputs: clock, reset_n, restart, active.
  - Outputs: go, step_count, wdog_hit.
- ulam_run_ctrl keeps the FSM, done_mask, flags and run_index.

Test Plan:
1. Reset and single run:
   - Setup: NCH=2, STEP_DIV=1, WDOG_LIMIT=8. Reset, then a start pulse.
   - Expected: clear in cycle 1, enable in cycle 2, run from cycle 3; done=2'b01 at go #3 and 2'b10 at go #5 -> FINISH, step_count=5, run_index=1, timed_out=0.
2. Watchdog:
   - Setup: same parameters, done held 0.
   - Expected: exactly 8 go pulses, then ABORT with timed_out=1, aborted=0, step_count=8, run stays low afterwards.
3. Simultaneous events:
   - Last done bit on the same cycle step_count==8 -> FINISH, not timeout.
   - alert on the same cycle as the final done -> ABORT with aborted=1.
4. Prescaler:
   - Setup: STEP_DIV=3.
   - Expected: go on RUN cycles 3, 6, 9; step_count increments only on those cycles.
5. Auto-restart:
   - Setup: AUTO_RESTART=1, IDX_W=2, done forced to all ones after one step.
   - Expected: FINISH -> CLEAR loops repeat; run_index runs 1, 2, 3, 0 (wrap).
6. Reset mid-run:
   - Stimulus: reset_n low during RUN at step_count=4.
   - Expected: all outputs 0 immediately (asynchronous); after release, state is IDLE and start is required to run again.
